// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path:
// default widths, the hard-wired zero register, requester identity and the write command.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic [ADDR_W-1:0] regNum;
    logic [DATA_W-1:0] data;
  } wb_cmd_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback, wiped by flush; two combinational hazard read ports.
module wb_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setIdx,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrIdx,
  input  logic [ADDR_W-1:0] rdA,
  input  logic [ADDR_W-1:0] rdB,
  output logic              hazardA,
  output logic              hazardB
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pendingNext_s;
  logic [NREG-1:0] setMask_s;
  logic [NREG-1:0] clrMask_s;

  // Next pending vector; set is applied after clear so an issue wins over a same-edge writeback
  always_comb begin
    setMask_s     = {NREG{1'b0}};
    clrMask_s     = {NREG{1'b0}};
    pendingNext_s = pending_r;
    if (clrEn) begin
      clrMask_s[clrIdx] = 1'b1;
    end else begin
      clrMask_s = {NREG{1'b0}};
    end
    if (setEn && (setIdx != ADDR_W'(REG_ZERO))) begin
      setMask_s[setIdx] = 1'b1;
    end else begin
      setMask_s = {NREG{1'b0}};
    end
    if (flush) begin
      pendingNext_s = {NREG{1'b0}};
    end else begin
      pendingNext_s = (pending_r & ~clrMask_s) | setMask_s;
    end
  end

  // Pending vector state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pendingNext_s;
    end
  end

  // Register 0 is hard-wired, so it never reports a hazard
  assign hazardA = pending_r[rdA] && (rdA != ADDR_W'(REG_ZERO));
  assign hazardB = pending_r[rdB] && (rdB != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load
// writeback paths, with a registered write command, retired-write counter and hazard scoreboard.
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  wb_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] regNum;
    logic [DATA_W-1:0] data;
  } cmd_t;

  req_e              rrPtr_r;
  req_e              rrPtrNext_s;
  logic              grantAlu_s;
  logic              grantMem_s;
  logic              xfer_s;
  logic              writes_s;
  cmd_t              selCmd_s;
  logic              wrEn_r;
  logic [ADDR_W-1:0] wrReg_r;
  logic [DATA_W-1:0] wrData_r;
  logic [CNT_W-1:0]  wbCount_r;

  // Grant decision; the pointer only moves when both sides compete
  always_comb begin
    grantAlu_s  = 1'b0;
    grantMem_s  = 1'b0;
    rrPtrNext_s = rrPtr_r;
    if (reset || flush) begin
      grantAlu_s = 1'b0;
      grantMem_s = 1'b0;
    end else if (alu_valid && mem_valid) begin
      case (rrPtr_r)
        REQ_ALU: begin
          grantAlu_s  = 1'b1;
          rrPtrNext_s = REQ_MEM;
        end
        REQ_MEM: begin
          grantMem_s  = 1'b1;
          rrPtrNext_s = REQ_ALU;
        end
        default: begin
          grantAlu_s  = 1'b1;
          rrPtrNext_s = REQ_MEM;
        end
      endcase
    end else begin
      grantAlu_s = alu_valid;
      grantMem_s = mem_valid;
    end
  end

  // Grant mux
  always_comb begin
    selCmd_s.regNum = alu_reg;
    selCmd_s.data   = alu_data;
    if (grantMem_s) begin
      selCmd_s.regNum = mem_reg;
      selCmd_s.data   = mem_data;
    end else begin
      selCmd_s.regNum = alu_reg;
      selCmd_s.data   = alu_data;
    end
  end

  assign xfer_s   = grantAlu_s || grantMem_s;
  assign writes_s = xfer_s && (selCmd_s.regNum != ADDR_W'(REG_ZERO));

  // Round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr_r <= REQ_ALU;
    end else begin
      rrPtr_r <= rrPtrNext_s;
    end
  end

  // Write command register; a reg-0 transfer retires without touching the register file
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrEn_r   <= 1'b0;
      wrReg_r  <= {ADDR_W{1'b0}};
      wrData_r <= {DATA_W{1'b0}};
    end else begin
      wrEn_r <= writes_s;
      if (writes_s) begin
        wrReg_r  <= selCmd_s.regNum;
        wrData_r <= selCmd_s.data;
      end
    end
  end

  // Retired-write counter, free-running wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbCount_r <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      wbCount_r <= wbCount_r + CNT_W'(1);
    end
  end

  wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) uScoreboard (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .setEn  (issue_valid),
    .setIdx (issue_dest),
    .clrEn  (xfer_s),
    .clrIdx (selCmd_s.regNum),
    .rdA    (rd_a),
    .rdB    (rd_b),
    .hazardA(hazard_a),
    .hazardB(hazard_b)
  );

  assign alu_ready = grantAlu_s;
  assign mem_ready = grantMem_s;
  assign wr_en     = wrEn_r;
  assign wr_reg    = wrReg_r;
  assign wr_data   = wrData_r;
  assign wb_count  = wbCount_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized checks of regfile_wb_arbiter against a behavioural model
// (pending set, turn flag, expected write) kept in the bench.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_reg, mem_reg, issue_dest, rd_a, rd_b, wr_reg;
  logic [31:0] alu_data, mem_data, wr_data;
  logic        issue_valid, flush, hazard_a, hazard_b, wr_en;
  logic [15:0] wb_count;

  int          nTests = 0;
  int          nFail  = 0;

  bit          mPend[32];
  int          mTurn;
  int          lastWin;
  logic        expWrEn;
  logic [4:0]  expReg;
  logic [31:0] expData;
  logic [15:0] expCount;
  int          seq3[4] = '{3, 4, 3, 4};

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .flush(flush),
    .rd_a(rd_a), .rd_b(rd_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    mTurn    = 0;
    lastWin  = -1;
    expWrEn  = 1'b0;
    expReg   = 5'd0;
    expData  = 32'd0;
    expCount = 16'd0;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  // One clock: inputs already set just after a negedge; ends at the next negedge
  task automatic step();
    int          win;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    #1;
    win = -1;
    if (!flush) begin
      if (alu_valid && mem_valid) win = mTurn;
      else if (alu_valid) win = 0;
      else if (mem_valid) win = 1;
    end
    chk("alu_ready", alu_ready, win == 0);
    chk("mem_ready", mem_ready, win == 1);
    chk("hazard_a", hazard_a, (rd_a != 5'd0) && mPend[rd_a]);
    chk("hazard_b", hazard_b, (rd_b != 5'd0) && mPend[rd_b]);
    lastWin = win;
    @(posedge clock);
    wreg  = (win == 1) ? mem_reg : alu_reg;
    wdata = (win == 1) ? mem_data : alu_data;
    expWrEn = 1'b0;
    if (win >= 0) begin
      expCount = expCount + 16'd1;
      if (wreg != 5'd0) begin
        expWrEn = 1'b1;
        expReg  = wreg;
        expData = wdata;
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    end else begin
      if (win >= 0) mPend[wreg] = 1'b0;
      if (issue_valid && issue_dest != 5'd0) mPend[issue_dest] = 1'b1;
      if (alu_valid && mem_valid) mTurn = 1 - mTurn;
    end
    @(negedge clock);
    chk("wr_en", wr_en, expWrEn);
    if (expWrEn) begin
      chk("wr_reg", wr_reg, expReg);
      chk("wr_data", wr_data, expData);
    end
    chk("wb_count", wb_count, expCount);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    alu_reg = 5'd0; alu_data = 32'd0; mem_reg = 5'd0; mem_data = 32'd0;
    issue_dest = 5'd0; rd_a = 5'd0; rd_b = 5'd0;
    modelReset();

    // 1: reset state, ready suppressed during reset, no hazards anywhere
    @(negedge clock);
    alu_valid = 1'b1;
    #1 chk("rst_alu_ready", alu_ready, 1'b0);
    alu_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_reg", wr_reg, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wb_count", wb_count, 16'd0);
    for (int i = 0; i < 32; i++) begin
      rd_a = 5'(i);
      rd_b = 5'(31 - i);
      #1;
      chk("rst_hazard_a", hazard_a, 1'b0);
      chk("rst_hazard_b", hazard_b, 1'b0);
    end
    @(negedge clock);

    // 2: single ALU write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("t2_wr_en", wr_en, 1'b1);
    chk("t2_wr_reg", wr_reg, 5'd5);
    chk("t2_wr_data", wr_data, 32'hDEADBEEF);
    chk("t2_wb_count", wb_count, 16'd1);
    idle();

    // 3: both valid for four cycles alternate starting with ALU
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA0A0_0003;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hB0B0_0004;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_wr_reg", wr_reg, 5'(seq3[k]));
    end
    idle();

    // 4: issue/clear/same-edge set-wins on reg 7
    issue_valid = 1'b1; issue_dest = 5'd7;
    step();
    issue_valid = 1'b0; rd_a = 5'd7;
    #1 chk("t4_haz_set", hazard_a, 1'b1);
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h0000_0777;
    step();
    mem_valid = 1'b0;
    #1 chk("t4_haz_clr", hazard_a, 1'b0);
    issue_valid = 1'b1; issue_dest = 5'd7;
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h0000_0778;
    step();
    idle();
    #1 chk("t4_haz_setwins", hazard_a, 1'b1);

    // 5: register 0 retires without writing and never becomes pending
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1234_5678;
    step();
    chk("t5_wr_en", wr_en, 1'b0);
    idle();
    issue_valid = 1'b1; issue_dest = 5'd0; rd_b = 5'd0;
    step();
    idle();
    #1 chk("t5_haz_b", hazard_b, 1'b0);

    // 6: flush wipes pending and blocks grants; reset drops an in-flight write
    issue_valid = 1'b1; issue_dest = 5'd1; step();
    issue_dest = 5'd2; step();
    issue_dest = 5'd31; step();
    issue_dest = 5'd9; flush = 1'b1;
    alu_valid = 1'b1; alu_reg = 5'd1; mem_valid = 1'b1; mem_reg = 5'd2;
    step();
    idle();
    rd_a = 5'd1; rd_b = 5'd31;
    #1;
    chk("t6_haz_a1", hazard_a, 1'b0);
    chk("t6_haz_b31", hazard_b, 1'b0);
    rd_a = 5'd2;
    #1 chk("t6_haz_a2", hazard_a, 1'b0);
    @(negedge clock);
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'hCAFE_F00D;
    step();
    chk("t6_pre_rst_wr_en", wr_en, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_wr_en", wr_en, 1'b0);
    chk("t6_rst_ready", alu_ready, 1'b0);
    chk("t6_rst_count", wb_count, 16'd0);
    idle();
    modelReset();
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic; requesters hold a request until it is accepted
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!alu_valid || lastWin == 0) begin
        alu_valid = ($urandom % 3) != 0;
        alu_reg   = 5'($urandom_range(0, 7));
        alu_data  = 32'($urandom);
      end
      if (!mem_valid || lastWin == 1) begin
        mem_valid = ($urandom % 3) != 0;
        mem_reg   = 5'($urandom_range(0, 7));
        mem_data  = 32'($urandom);
      end
      issue_valid = ($urandom % 2) != 0;
      issue_dest  = 5'($urandom_range(0, 7));
      flush       = ($urandom % 16) == 0;
      rd_a        = 5'($urandom_range(0, 7));
      rd_b        = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
